// File: rtl/feedthrough_channel_arbiter.sv
// Round-robin arbiter that lends one narrow routed channel to NUM_REQ requesters.
// A grant lasts until a last beat, the burst-length limit, or the grantee drops valid.
module feedthrough_channel_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 2,
   parameter int MAX_BURST = 4,
   parameter int ID_W      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      ch_valid,
   output logic [DATA_W-1:0]         ch_data,
   input  logic                      ch_ready,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic [DATA_W-1:0]  data_arr [NUM_REQ];
   logic               sel_found;
   logic [ID_W-1:0]    sel_id;
   logic [ID_W-1:0]    next_ptr;
   logic               beat;
   logic               at_limit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      sel_found = 1'b0;
      sel_id    = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!sel_found && req_valid[idx]) begin
            sel_found = 1'b1;
            sel_id    = ID_W'(idx);
         end
      end
   end

   assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
   assign at_limit = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
   assign beat     = ch_valid & ch_ready;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      ch_valid    = 1'b0;
      ch_data     = '0;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_id_d  = sel_id;
               burst_cnt_d = '0;
               state_d     = XFER;
            end
         end
         XFER: begin
            ch_valid              = req_valid[grant_id_q];
            ch_data               = data_arr[grant_id_q];
            req_ready[grant_id_q] = ch_ready;
            if (!req_valid[grant_id_q]) begin
               state_d = IDLE;
               ptr_d   = next_ptr;
            end else if (beat) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
               if (req_last[grant_id_q] || at_limit) begin
                  state_d = IDLE;
                  ptr_d   = next_ptr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_id_q  <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q == XFER);

endmodule
